window_threshold_detector: RTL and testbench

Parametrised, sequential generalisation of the 3-input pair/triple detector. Each valid sample is an N-bit vector. A sample is a "hit" when at least K of its bits are set. The block keeps a sliding window over the last W valid samples and asserts `detect` while at least M of those samples were hits. It sits between sampled input lanes and downstream control logic that needs a debounced "majority seen often enough" flag.

---
 rtl/window_threshold_detector.sv | 110 +++++++++++
 tb/tb_window_threshold_detector.sv | 138 +++++++++++++
 2 files changed

// File: rtl/window_threshold_detector.sv
// Sliding-window hit detector: a sample is a hit when at least K of its N bits are set,
// and detect stays high while at least M of the last W accepted samples were hits.
module window_threshold_detector #(
  parameter int N = 3,
  parameter int K = 2,
  parameter int W = 4,
  parameter int M = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_val,
  input  logic [N-1:0]             in_data,
  output logic [$clog2(N+1)-1:0]   pop,
  output logic                     hit,
  output logic [$clog2(W+1)-1:0]   count,
  output logic                     detect,
  output logic                     detect_rise
);

  localparam int PW = $clog2(N+1);
  localparam int CW = $clog2(W+1);
  localparam logic [PW-1:0] K_P = PW'(K);
  localparam logic [CW-1:0] M_P = CW'(M);

  function automatic logic [PW-1:0] popcount(input logic [N-1:0] d);
    logic [PW-1:0] p;
    p = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      p = p + PW'(d[i]);
    end
    return p;
  endfunction

  logic [PW-1:0] pop_q, pop_d;
  logic          hit_q, hit_d;
  logic [W-1:0]  hist_q, hist_d;
  logic [CW-1:0] count_q, count_d;
  logic          detect_q, detect_d;
  logic          rise_q, rise_d;

  logic [PW-1:0] sample_pop;
  logic          sample_hit;
  logic [CW:0]   cnt_ext;
  logic [CW-1:0] cnt_next;
  logic          detect_next;

  // Next-state logic: clear beats accept, idle cycles hold everything but the rise pulse.
  always_comb begin
    pop_d       = pop_q;
    hit_d       = hit_q;
    hist_d      = hist_q;
    count_d     = count_q;
    detect_d    = detect_q;
    rise_d      = 1'b0;
    sample_pop  = popcount(in_data);
    sample_hit  = (sample_pop >= K_P);
    // Entry W-1 is the oldest; a window not yet full holds zeros there.
    cnt_ext     = {1'b0, count_q} + {{CW{1'b0}}, sample_hit} - {{CW{1'b0}}, hist_q[W-1]};
    if (cnt_ext[CW]) begin
      cnt_next = {CW{1'b0}};
    end else begin
      cnt_next = cnt_ext[CW-1:0];
    end
    detect_next = (cnt_next >= M_P);
    if (clear) begin
      pop_d    = {PW{1'b0}};
      hit_d    = 1'b0;
      hist_d   = {W{1'b0}};
      count_d  = {CW{1'b0}};
      detect_d = 1'b0;
      rise_d   = 1'b0;
    end else if (in_val) begin
      pop_d    = sample_pop;
      hit_d    = sample_hit;
      hist_d   = W'({hist_q, sample_hit});
      count_d  = cnt_next;
      detect_d = detect_next;
      rise_d   = detect_next & ~detect_q;
    end else begin
      rise_d   = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q    <= {PW{1'b0}};
      hit_q    <= 1'b0;
      hist_q   <= {W{1'b0}};
      count_q  <= {CW{1'b0}};
      detect_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      pop_q    <= pop_d;
      hit_q    <= hit_d;
      hist_q   <= hist_d;
      count_q  <= count_d;
      detect_q <= detect_d;
      rise_q   <= rise_d;
    end
  end

  assign pop         = pop_q;
  assign hit         = hit_q;
  assign count       = count_q;
  assign detect      = detect_q;
  assign detect_rise = rise_q;

endmodule

// File: tb/tb_window_threshold_detector.sv
// Directed table-driven bench for window_threshold_detector at N=3, K=2, W=4, M=3.
module tb_window_threshold_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_val;
  logic [2:0] in_data;
  logic [1:0] pop;
  logic       hit;
  logic [2:0] count;
  logic       detect;
  logic       detect_rise;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic       c;
    logic [2:0] d;
    logic [1:0] pop;
    logic       hit;
    logic [2:0] cnt;
    logic       det;
    logic       rise;
  } vec_t;

  vec_t vecs[$];

  window_threshold_detector #(.N(3), .K(2), .W(4), .M(3)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(in_val), .in_data(in_data),
    .pop(pop), .hit(hit), .count(count), .detect(detect), .detect_rise(detect_rise)
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, input logic c, input logic [2:0] d, input logic [1:0] p,
                     input logic h, input logic [2:0] cn, input logic de, input logic r);
    vec_t x;
    x.v = v; x.c = c; x.d = d; x.pop = p; x.hit = h; x.cnt = cn; x.det = de; x.rise = r;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [1:0] p, input logic h,
                       input logic [2:0] cn, input logic de, input logic r);
    n_vec++;
    if (pop !== p || hit !== h || count !== cn || detect !== de || detect_rise !== r) begin
      n_bad++;
      $display("FAIL %s: got pop=%0d hit=%0b count=%0d detect=%0b rise=%0b, want pop=%0d hit=%0b count=%0d detect=%0b rise=%0b",
               name, pop, hit, count, detect, detect_rise, p, h, cn, de, r);
    end
  endtask

  task automatic step(input logic v, input logic c, input logic [2:0] d);
    in_val = v; clear = c; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Truth table with a gap after each accept.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] d;
      logic [1:0] p;
      logic       h;
      logic [2:0] cn;
      logic       de;
      logic       r;
      d  = 3'(i);
      p  = 2'(d[0]) + 2'(d[1]) + 2'(d[2]);
      h  = (p >= 2'd2);
      cn = (i < 3) ? 3'd0 : (i < 5) ? 3'd1 : (i == 5) ? 3'd2 : 3'd3;
      de = (i >= 6);
      r  = (i == 6);
      add(1'b1, 1'b0, d, p, h, cn, de, r);
      add(1'b0, 1'b0, 3'b000, p, h, cn, de, 1'b0);
    end
    add(1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    // Window fill.
    add(1'b1, 1'b0, 3'b011, 2'd2, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b110, 2'd2, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b001, 2'd1, 1'b0, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd3, 1'b1, 1'b1);
    // Wrap-around: hits drop out of the oldest slot.
    add(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd3, 1'b1, 1'b1);
    // Full window of hits, then valid gaps.
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd4, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 3'b111, 2'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    add(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd2, 1'b0, 1'b0);
    // Rebuild to count=3, then clear collides with a valid sample.
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd3, 1'b1, 1'b1);
    add(1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, 3'b111, 2'd3, 1'b1, 3'd3, 1'b1, 1'b1);

    rst_n = 1'b0; clear = 1'b0; in_val = 1'b0; in_data = 3'b000;
    for (int i = 0; i < 3; i++) begin
      in_val  = 1'($urandom_range(1));
      clear   = 1'($urandom_range(1));
      in_data = 3'($urandom_range(7));
      @(posedge clk);
      #1;
      check("reset_hold", 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].c, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].pop, vecs[i].hit, vecs[i].cnt, vecs[i].det, vecs[i].rise);
    end

    // Asynchronous reset in mid-cycle while detect is high.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'b111);
    check("reset_held", 2'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3'b111);
    check("after_reset", 2'd3, 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 3'b000);
    check("after_reset_idle", 2'd3, 1'b1, 3'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
